// File: rtl/gf2_osd_solver.sv
// gf2_osd_solver
//   Solves Hs * x = syndrome over GF(2) by sequential incremental Gaussian elimination and
//   scatters x into a full-length OSD-0 error estimate.
//
//   Columns are reduced one at a time against the already-stored basis. Each basis slot
//   keeps:
//     - the reduced column r_k
//     - its pivot p_k, the lowest set bit of r_k
//     - a combination mask m_k, recording which original columns make up r_k
//   The syndrome is then reduced against the basis. The XOR of the masks it consumed is x.
//
// Ports
//   clk_i, rst_ni      clock, asynchronous active-low reset
//   start_i            begin a solve; sampled only while idle
//   syndrome_i         target vector, latched on an accepted start
//   rank_in_i          number of valid columns, latched on an accepted start
//                      (values above RANK_MAX are clamped to RANK_MAX)
//   hs_cols_i          selected columns; must be stable from start to done
//   used_indices_i     error index of each column; must be stable from start to done
//   busy_o             high from the accepted start until done rises
//   done_o             level; held until the next accepted start
//   dependent_o        some column reduced to zero (valid with done)
//   unsolvable_o       syndrome is not in the span of Hs (valid with done)
//   err_est_o          error estimate (valid with done)
module gf2_osd_solver #(
   parameter int unsigned N_DET    = 936,
   parameter int unsigned N_ERR    = 8784,
   parameter int unsigned RANK_MAX = 936,
   parameter int unsigned IW       = $clog2(N_ERR),
   parameter int unsigned RW       = $clog2(RANK_MAX + 1)
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             start_i,
   input  logic [N_DET-1:0] syndrome_i,
   input  logic [RW-1:0]    rank_in_i,
   input  logic [N_DET-1:0] hs_cols_i      [RANK_MAX],
   input  logic [IW-1:0]    used_indices_i [RANK_MAX],
   output logic             busy_o,
   output logic             done_o,
   output logic             dependent_o,
   output logic             unsolvable_o,
   output logic [N_ERR-1:0] err_est_o
);

   // Slot index width (counters are RW bits wide; slots are addressed with the low KW bits).
   localparam int unsigned KW = (RANK_MAX > 1) ? $clog2(RANK_MAX) : 1;
   localparam int unsigned PW = (N_DET > 1) ? $clog2(N_DET) : 1;

   typedef enum logic [2:0] {
      StIdle, StCload, StCelim, StCstore, StSload, StSolve, StScatter, StFin
   } state_e;

   state_e state_q, state_d;

   logic [RW-1:0]       j_q, j_d, k_q, k_d, rank_q, rank_d;
   logic [N_DET-1:0]    syn_q, syn_d, v_q, v_d, s_q, s_d;
   logic [RANK_MAX-1:0] m_q, m_d, x_q, x_d;
   logic [N_ERR-1:0]    err_q, err_d;
   logic                busy_q, busy_d, done_q, done_d;
   logic                dep_q, dep_d, uns_q, uns_d;

   // Basis storage
   logic [N_DET-1:0]    r_q  [RANK_MAX];
   logic [RANK_MAX-1:0] mk_q [RANK_MAX];
   logic [PW-1:0]       p_q  [RANK_MAX];
   logic [RANK_MAX-1:0] vld_q;
   logic                slot_we;

   logic [KW-1:0]       jx, kx;
   logic [RW-1:0]       rank_clamp;
   logic [PW-1:0]       piv;

   assign jx = j_q[KW-1:0];
   assign kx = k_q[KW-1:0];
   assign rank_clamp = (rank_in_i > RW'(RANK_MAX)) ? RW'(RANK_MAX) : rank_in_i;

   // Lowest set bit of the column being stored; 0 when the column is all zero.
   always_comb begin
      piv = '0;
      for (int b = N_DET - 1; b >= 0; b--) begin
         if (v_q[b]) piv = PW'(b);
      end
   end

   always_comb begin
      state_d = state_q;
      j_d     = j_q;
      k_d     = k_q;
      rank_d  = rank_q;
      syn_d   = syn_q;
      v_d     = v_q;
      m_d     = m_q;
      s_d     = s_q;
      x_d     = x_q;
      err_d   = err_q;
      busy_d  = busy_q;
      done_d  = done_q;
      dep_d   = dep_q;
      uns_d   = uns_q;
      slot_we = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (start_i) begin
               rank_d  = rank_clamp;
               syn_d   = syndrome_i;
               err_d   = '0;
               dep_d   = 1'b0;
               uns_d   = 1'b0;
               done_d  = 1'b0;
               busy_d  = 1'b1;
               j_d     = '0;
               state_d = (rank_clamp == '0) ? StSload : StCload;
            end
         end
         StCload: begin
            v_d     = hs_cols_i[jx];
            m_d     = '0;
            m_d[jx] = 1'b1;
            k_d     = '0;
            state_d = (j_q == '0) ? StCstore : StCelim;
         end
         StCelim: begin
            // A dependent slot has r_k = 0 and p_k = 0; the valid bit keeps it from matching.
            if (vld_q[kx] && v_q[p_q[kx]]) begin
               v_d = v_q ^ r_q[kx];
               m_d = m_q ^ mk_q[kx];
            end
            k_d = k_q + RW'(1);
            if ((k_q + RW'(1)) == j_q) state_d = StCstore;
         end
         StCstore: begin
            slot_we = 1'b1;
            if (v_q == '0) dep_d = 1'b1;
            j_d     = j_q + RW'(1);
            state_d = ((j_q + RW'(1)) < rank_q) ? StCload : StSload;
         end
         StSload: begin
            s_d     = syn_q;
            x_d     = '0;
            k_d     = '0;
            state_d = (rank_q == '0) ? StFin : StSolve;
         end
         StSolve: begin
            if (vld_q[kx] && s_q[p_q[kx]]) begin
               s_d = s_q ^ r_q[kx];
               x_d = x_q ^ mk_q[kx];
            end
            k_d = k_q + RW'(1);
            if ((k_q + RW'(1)) == rank_q) begin
               k_d     = '0;
               state_d = StScatter;
            end
         end
         StScatter: begin
            // Sequential order makes the last duplicate index win.
            err_d[used_indices_i[kx]] = x_q[kx];
            k_d = k_q + RW'(1);
            if ((k_q + RW'(1)) == rank_q) state_d = StFin;
         end
         StFin: begin
            uns_d   = |s_q;
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= StIdle;
         j_q     <= '0;
         k_q     <= '0;
         rank_q  <= '0;
         syn_q   <= '0;
         v_q     <= '0;
         m_q     <= '0;
         s_q     <= '0;
         x_q     <= '0;
         err_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         dep_q   <= 1'b0;
         uns_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         j_q     <= j_d;
         k_q     <= k_d;
         rank_q  <= rank_d;
         syn_q   <= syn_d;
         v_q     <= v_d;
         m_q     <= m_d;
         s_q     <= s_d;
         x_q     <= x_d;
         err_q   <= err_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         dep_q   <= dep_d;
         uns_q   <= uns_d;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int i = 0; i < RANK_MAX; i++) begin
            r_q[i]  <= '0;
            mk_q[i] <= '0;
            p_q[i]  <= '0;
         end
         vld_q <= '0;
      end else if (slot_we) begin
         r_q[jx]   <= v_q;
         mk_q[jx]  <= m_q;
         p_q[jx]   <= piv;
         vld_q[jx] <= |v_q;
      end
   end

   assign busy_o       = busy_q;
   assign done_o       = done_q;
   assign dependent_o  = dep_q;
   assign unsolvable_o = uns_q;
   assign err_est_o    = err_q;

endmodule

// File: tb/tb_gf2_osd_solver.sv
// Directed bench for gf2_osd_solver with N_DET=4, N_ERR=8, RANK_MAX=4.
module tb_gf2_osd_solver;

   localparam int ND = 4;
   localparam int NE = 8;
   localparam int RM = 4;
   localparam int IW = 3;
   localparam int RW = 3;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          start;
   logic [ND-1:0] syn;
   logic [RW-1:0] rank;
   logic [ND-1:0] hs  [RM];
   logic [IW-1:0] idx [RM];
   logic          busy, done, dep, uns;
   logic [NE-1:0] err;

   int n_cmp  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   gf2_osd_solver #(
      .N_DET   (ND),
      .N_ERR   (NE),
      .RANK_MAX(RM),
      .IW      (IW),
      .RW      (RW)
   ) dut (
      .clk_i         (clk),
      .rst_ni        (rst_n),
      .start_i       (start),
      .syndrome_i    (syn),
      .rank_in_i     (rank),
      .hs_cols_i     (hs),
      .used_indices_i(idx),
      .busy_o        (busy),
      .done_o        (done),
      .dependent_o   (dep),
      .unsolvable_o  (uns),
      .err_est_o     (err)
   );

   typedef struct {
      logic [2:0]  rank;
      logic [3:0]  syn;
      logic [15:0] cols;   // {col3, col2, col1, col0}
      logic [11:0] idxs;   // {idx3, idx2, idx1, idx0}
      logic [7:0]  err;
      logic        dep;
      logic        uns;
      int          lat;
   } vec_t;

   vec_t vecs[9];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic apply(input vec_t v);
      rank = v.rank;
      syn  = v.syn;
      for (int i = 0; i < RM; i++) begin
         hs[i]  = v.cols[i*4 +: 4];
         idx[i] = v.idxs[i*3 +: 3];
      end
   endtask

   // inj > 0 raises start (with a scrambled syndrome) so that edge inj samples it mid-run.
   task automatic run_vec(input vec_t v, input int inj, input string tag);
      int lat;
      apply(v);
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      check({tag, " busy after accept"}, 32'(busy), 32'd1);
      lat = 0;
      for (int e = 1; e <= 200; e++) begin
         if (e == inj) begin
            start = 1'b1;
            syn   = ~v.syn;
         end
         @(posedge clk);
         #1;
         start = 1'b0;
         syn   = v.syn;
         if (done) begin
            lat = e;
            break;
         end
      end
      check({tag, " latency"}, 32'(lat), 32'(v.lat));
      check({tag, " err_est"}, 32'(err), 32'(v.err));
      check({tag, " dependent"}, 32'(dep), 32'(v.dep));
      check({tag, " unsolvable"}, 32'(uns), 32'(v.uns));
      check({tag, " busy at done"}, 32'(busy), 32'd0);
   endtask

   initial begin
      //          rank  syn      cols                                  idxs
      vecs[0] = '{3'd3, 4'b0101, {4'b0000, 4'b1100, 4'b0110, 4'b0011}, {3'd0, 3'd7, 3'd2, 3'd5},
                  8'b0010_0100, 1'b0, 1'b0, 17};
      vecs[1] = '{3'd2, 4'b0100, {4'b0000, 4'b0000, 4'b0010, 4'b0001}, {3'd0, 3'd0, 3'd1, 3'd0},
                  8'b0000_0000, 1'b0, 1'b1, 11};
      vecs[2] = '{3'd3, 4'b0011, {4'b0000, 4'b0101, 4'b0110, 4'b0011}, {3'd0, 3'd6, 3'd3, 3'd1},
                  8'b0000_0010, 1'b1, 1'b0, 17};
      vecs[3] = '{3'd0, 4'b0000, 16'h0000, 12'h000, 8'b0000_0000, 1'b0, 1'b0, 2};
      vecs[4] = '{3'd0, 4'b1000, 16'h0000, 12'h000, 8'b0000_0000, 1'b0, 1'b1, 2};
      // rank 5 clamps to 4
      vecs[5] = '{3'd5, 4'b1010, {4'b1000, 4'b0100, 4'b0010, 4'b0001}, {3'd3, 3'd2, 3'd1, 3'd0},
                  8'b0000_1010, 1'b0, 1'b0, 24};
      // duplicate index 4: x = 01, the later write of 0 wins
      vecs[6] = '{3'd2, 4'b0001, {4'b0000, 4'b0000, 4'b0010, 4'b0001}, {3'd0, 3'd0, 3'd4, 3'd4},
                  8'b0000_0000, 1'b0, 1'b0, 11};
      vecs[7] = '{3'd2, 4'b0011, {4'b0000, 4'b0000, 4'b0011, 4'b0011}, {3'd0, 3'd0, 3'd7, 3'd0},
                  8'b0000_0001, 1'b1, 1'b0, 11};
      // dependent slot 1 has pivot 0; it must not touch col2 (bit 0) or the syndrome
      vecs[8] = '{3'd3, 4'b0011, {4'b0000, 4'b0001, 4'b0010, 4'b0010}, {3'd0, 3'd4, 3'd5, 3'd6},
                  8'b0101_0000, 1'b1, 1'b0, 17};

      rst_n = 1'b0;
      start = 1'b0;
      apply(vecs[3]);
      #12;
      check("reset outputs", {busy, done, dep, uns, err}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < 9; i++) begin
         run_vec(vecs[i], 0, $sformatf("vec%0d", i));
      end

      // start pulses while busy must be ignored
      run_vec(vecs[0], 5, "busy-start");

      // asynchronous reset in the middle of column elimination
      apply(vecs[0]);
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (6) @(posedge clk);
      #1;
      check("mid-run busy", 32'(busy), 32'd1);
      rst_n = 1'b0;
      #1;
      check("abort outputs", {busy, done, dep, uns, err}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (20) @(posedge clk);
      #1;
      check("no partial done", {busy, done}, 32'd0);
      run_vec(vecs[8], 0, "after-abort");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/gf2_osd_solver.md
Name: gf2_osd_solver

Overview:
- Downstream of the matrix selector in the OSD decode path.
- Takes the RANK selected, independent parity-check columns Hs and their error indices, and solves Hs·x = syndrome over GF(2) by sequential incremental Gaussian elimination.
- Scatters the solution x into a full-length OSD-0 error estimate for the post-processing/verification stage.

Parameters:
- N_DET, 936: detector count; width of each column and of the syndrome.
- N_ERR, 8784: error-mechanism count; width of the error estimate.
- RANK_MAX, 936: maximum number of selected columns.
- IW, $clog2(N_ERR): index width.
- RW, $clog2(RANK_MAX+1): rank width.

Ports:
- clk, in, 1: clock.
- rst_n, in, 1: asynchronous active-low reset.
- start, in, 1: begin solve; sampled only in IDLE.
- syndrome, in, N_DET: target vector; latched on accepted start.
- rank_in, in, RW: number of valid columns; latched on accepted start.
- Hs_cols, in, [N_DET-1:0] x RANK_MAX: selected columns; stable from start to done.
- used_indices, in, [IW-1:0] x RANK_MAX: error index of each column; stable from start to done.
- busy, out, 1: high from accepted start until done rises.
- done, out, 1: level; held until next accepted start or reset.
- dependent, out, 1: some column reduced to zero; valid with done.
- unsolvable, out, 1: syndrome is not in the span of Hs; valid with done.
- err_est, out, N_ERR: error estimate; valid with done.

Behaviour:
- Reset, async on rst_n=0: state=IDLE; busy, done, dependent, unsolvable, err_est all 0; internal basis and counters cleared. Reset mid-operation aborts with no partial done.
- Storage per basis slot k: reduced column r_k (N_DET), pivot p_k (lowest set bit of r_k), combination mask m_k (RANK_MAX bits).
- IDLE: on start=1, latch syndrome and rank_in (values above RANK_MAX are clamped), clear err_est/dependent/unsolvable, set done=0, busy=1, j=0. Go to CLOAD, or to SLOAD if rank=0. start while busy=1 is ignored.
- CLOAD (1 cycle): v=Hs_cols[j], m=onehot(j), k=0.
- CELIM (j cycles, k=0..j-1): if v[p_k], then v^=r_k and m^=m_k.
- CSTORE (1 cycle): r_j=v, m_j=m, p_j=priority-encode lowest set bit of v. If v==0, set dependent=1 and p_j=0; the slot must never match, so gate it with a valid bit. j++. Go to CLOAD if j<rank, else SLOAD.
- SLOAD (1 cycle): s=latched syndrome, x=0, k=0.
- SOLVE (rank cycles): if valid_k and s[p_k], then s^=r_k and x^=m_k.
- After SOLVE, unsolvable=|s.
- SCATTER (rank cycles, i=0..rank-1): err_est[used_indices[i]] = x[i]. Duplicate indices: last write wins.
- FIN (1 cycle): done=1, busy=0, go to IDLE.
- Latency: done rises L = R(R-1)/2 + 4R + 2 clock edges after the edge that accepts start (R = latched rank). R=0 gives 2; R=1 gives 6.
- Outputs hold after done until next accepted start.
- Column j cost is j+2 cycles; counters sized for RANK_MAX without overflow.
- The error estimate is produced even when unsolvable=1, as a least-effort partial solution; consumers must gate on the flag.

Test Plan:
- Use small parameters N_DET=4, N_ERR=8, RANK_MAX=4 for directed tests.
- Solvable: cols 0011, 0110, 1100; indices 5, 2, 7; syndrome 0101; rank 3 -> done at edge 17, err_est=00100100, unsolvable=0, dependent=0.
- Unsolvable: cols 0001, 0010; rank 2; syndrome 0100 -> unsolvable=1, err_est=0, done at edge 11.
- Dependent: cols 0011, 0110, 0101; rank 3; syndrome 0011 -> dependent=1, unsolvable=0, err_est has only index of col0 set.
- rank=0, syndrome 0000 -> done at edge 2, err_est=0, unsolvable=0. Same with syndrome 1000 -> unsolvable=1.
- Drop rst_n mid-CELIM -> busy/done/err_est immediately 0. A new start after release completes correctly. A start pulse asserted while busy is ignored, and the result matches an undisturbed run.
